// File: rtl/pattern_generator_param.sv
// pattern_generator_param: parametrised valid/ready test-pattern source with
// up-counter, PRBS7/15/31, memory playback and walking-one generators.
module pattern_generator_param #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              CLEAR,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [1:0]        prbs_sel,
    input  logic              seed_load,
    input  logic [30:0]       seed,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W:0]   len,
    input  logic              loop,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    output logic              period,
    output logic              done
);
    logic [WIDTH-1:0]  cnt_q, cnt_d, w_q, w_d, prbs_w;
    logic [30:0]       s_q, s_d, s_mask, s_fix, s_adv, seed_m;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              done_q, done_d, period_q, period_d;
    logic              xfer, fb, p_last, p_over;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    always_comb begin
        s_mask = prbs_sel == 2'd0 ? 31'h0000_007F : prbs_sel == 2'd1 ? 31'h0000_7FFF : 31'h7FFF_FFFF;
        // a state that masks to zero would lock the LFSR, so it is forced to 1
        s_fix  = (s_q & s_mask) == 31'd0 ? 31'd1 : s_q & s_mask;
        seed_m = (seed & s_mask) == 31'd0 ? 31'd1 : seed & s_mask;
        fb     = prbs_sel == 2'd0 ? s_fix[6] ^ s_fix[5] : prbs_sel == 2'd1 ? s_fix[14] ^ s_fix[13] : s_fix[30] ^ s_fix[27];
        s_adv  = {s_fix[29:0], fb} & s_mask;
        prbs_w = s_q[WIDTH-1:0] & s_mask[WIDTH-1:0];
        p_last = {1'b0, ptr_q} == len - (ADDR_W+1)'(1);
        p_over = {1'b0, ptr_q} >= len;
        out_valid = en & ~(mode == 2'd2 & (done_q | len == '0));
        xfer      = out_valid & out_ready;
        out_data  = !out_valid ? '0 : mode == 2'd0 ? cnt_q : mode == 2'd1 ? prbs_w : mode == 2'd2 ? mem_q[ptr_q] : w_q;
        cnt_d    = cnt_q;
        s_d      = s_fix;
        ptr_d    = ptr_q;
        done_d   = done_q;
        w_d      = w_q;
        period_d = 1'b0;
        if (xfer && mode == 2'd0) begin
            cnt_d    = cnt_q + WIDTH'(1);
            period_d = &cnt_q;
        end
        if (xfer && mode == 2'd1 && !seed_load) begin
            s_d      = s_adv;
            period_d = s_adv == 31'd1;
        end
        if (seed_load)
            s_d = seed_m;
        if (xfer && mode == 2'd2) begin
            ptr_d    = (p_last || p_over) ? (loop ? '0 : ptr_q) : ptr_q + ADDR_W'(1);
            done_d   = (p_last || p_over) & ~loop;
            period_d = p_last;
        end
        if (xfer && mode == 2'd3) begin
            w_d      = {w_q[WIDTH-2:0], w_q[WIDTH-1]};
            period_d = w_q[WIDTH-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (CLEAR) begin
            cnt_q    <= '0;
            s_q      <= 31'd1;
            ptr_q    <= '0;
            done_q   <= 1'b0;
            w_q      <= WIDTH'(1);
            period_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            s_q      <= s_d;
            ptr_q    <= ptr_d;
            done_q   <= done_d;
            w_q      <= w_d;
            period_q <= period_d;
        end
    end

    // playback memory is not reset, so its contents survive CLEAR
    always_ff @(posedge CLK) begin
        if (wr_en)
            mem_q[wr_addr] <= wr_data;
    end

    assign period = period_q;
    assign done   = done_q;
endmodule

// File: tb/tb_pattern_generator_param.sv
// tb_pattern_generator_param: randomized self-checking bench for pattern_generator_param
// against a behavioural model of the four generators.
module tb_pattern_generator_param;
    localparam int WIDTH = 16, DEPTH = 16, ADDR_W = 4;
    logic              CLK = 1'b0;
    logic              CLEAR, en, seed_load, wr_en, loop, out_ready;
    logic [1:0]        mode, prbs_sel;
    logic [30:0]       seed;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [ADDR_W:0]   len;
    logic              out_valid, period, done;
    logic [WIDTH-1:0]  out_data;
    logic [15:0]       mem_m [DEPTH];
    logic [15:0]       play_tab [5] = '{16'h0000, 16'h000F, 16'h0020, 16'h0202, 16'hF800};
    int                n_cmp = 0, n_bad = 0;

    always #5 CLK = ~CLK;

    pattern_generator_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .CLEAR(CLEAR), .en(en), .mode(mode), .prbs_sel(prbs_sel),
        .seed_load(seed_load), .seed(seed), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .len(len), .loop(loop), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .period(period), .done(done)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [30:0] order_mask(input int n);
        logic [30:0] m;
        m = (31'd1 << n) - 31'd1;
        return m;
    endfunction

    // Fibonacci LFSR as written in the polynomial description: new bit enters at bit 0
    function automatic logic [30:0] prbs_step(input logic [30:0] s, input int n, input int t);
        logic [30:0] nx;
        nx = ((s << 1) | {30'd0, s[n-1] ^ s[t-1]}) & order_mask(n);
        return nx;
    endfunction

    function automatic logic [30:0] seed_fix(input logic [30:0] sd, input int n);
        return (sd & order_mask(n)) == 31'd0 ? 31'd1 : sd & order_mask(n);
    endfunction

    task automatic mem_write(input int a, input logic [15:0] d);
        wr_en = 1'b1;
        wr_addr = ADDR_W'(a);
        wr_data = d;
        tick();
        wr_en = 1'b0;
        mem_m[a] = d;
    endtask

    task automatic pulse_clear();
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        CLEAR = 1'b1; en = 1'b1; mode = 2'd0; out_ready = 1'b1;
        tick(); tick();
        n_cmp++; if (out_data !== 16'h0000) begin n_bad++; $display("FAIL reset_cnt: got %h expected 0000", out_data); end
        n_cmp++; if (period !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got period=%b done=%b expected 0 0", period, done); end
        mode = 2'd3; #1;
        n_cmp++; if (out_data !== 16'h0001) begin n_bad++; $display("FAIL reset_walk: got %h expected 0001", out_data); end
        mode = 2'd1; #1;
        n_cmp++; if (out_data !== 16'h0001) begin n_bad++; $display("FAIL reset_prbs: got %h expected 0001", out_data); end
        mode = 2'd0; CLEAR = 1'b0; en = 1'b0; #1;
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 16'h0000) begin n_bad++; $display("FAIL en_off: got valid=%b data=%h expected 0 0000", out_valid, out_data); end
    endtask

    task automatic test_counter();
        int bad = 0, first = -1, pcount = 0, pidx = -1;
        logic [15:0] fa;
        en = 1'b1; mode = 2'd0; out_ready = 1'b1; #1;
        for (int i = 0; i <= 65536; i++) begin
            if (out_data !== 16'(i) || out_valid !== 1'b1) begin
                if (first < 0) begin first = i; fa = out_data; end
                bad++;
            end
            if (period === 1'b1) begin pcount++; pidx = i; end
            if (i < 65536) tick();
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL cnt_seq: %0d wrong words, first at %0d got %h expected %h", bad, first, fa, 16'(first)); end
        n_cmp++; if (pcount != 1 || pidx != 65536) begin n_bad++; $display("FAIL cnt_period: got %0d pulses last at %0d expected 1 at 65536", pcount, pidx); end
        n_cmp++; if (out_data !== 16'h0000) begin n_bad++; $display("FAIL cnt_wrap: got %h expected 0000", out_data); end
        out_ready = 1'b0;
    endtask

    task automatic test_prbs7();
        logic [15:0] tab [9] = '{16'h01, 16'h02, 16'h04, 16'h08, 16'h10, 16'h20, 16'h41, 16'h03, 16'h06};
        logic [30:0] s = 31'd1;
        int bad = 0, first = -1, pcount = 0, pidx = -1;
        mode = 2'd1; prbs_sel = 2'd0;
        pulse_clear();
        out_ready = 1'b1; #1;
        for (int i = 0; i <= 127; i++) begin
            if (i < 9) begin
                n_cmp++; if (out_data !== tab[i]) begin n_bad++; $display("FAIL prbs7_word%0d: got %h expected %h", i, out_data, tab[i]); end
            end
            if (out_data !== 16'(s)) begin if (first < 0) first = i; bad++; end
            if (period === 1'b1) begin pcount++; pidx = i; end
            if (i < 127) begin tick(); s = prbs_step(s, 7, 6); end
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL prbs7_seq: %0d wrong words, first at %0d", bad, first); end
        n_cmp++; if (pcount != 1 || pidx != 127 || out_data !== 16'h0001) begin n_bad++; $display("FAIL prbs7_period: got %0d pulses at %0d data %h expected 1 at 127 data 0001", pcount, pidx, out_data); end
        out_ready = 1'b0;
    endtask

    task automatic test_prbs15_seed();
        logic [30:0] s;
        int bad = 0;
        mode = 2'd1; prbs_sel = 2'd1;
        seed_load = 1'b1; seed = 31'd0; out_ready = 1'b0;
        tick();
        seed_load = 1'b0;
        n_cmp++; if (out_data !== 16'h0001) begin n_bad++; $display("FAIL prbs15_seed0: got %h expected 0001", out_data); end
        seed = 31'($urandom);
        s = seed_fix(seed, 15);
        seed_load = 1'b1; out_ready = 1'b1;
        tick();
        seed_load = 1'b0;
        n_cmp++; if (out_data !== 16'(s)) begin n_bad++; $display("FAIL prbs15_seed_over_xfer: got %h expected %h", out_data, 16'(s)); end
        for (int i = 0; i < 300; i++) begin
            tick();
            s = prbs_step(s, 15, 14);
            if (out_data !== 16'(s)) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL prbs15_seq: got %0d wrong words expected 0", bad); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_pressure();
        logic [30:0] s;
        logic exp_p = 1'b0, acc;
        int bad = 0, pbad = 0, n_acc = 0;
        mode = 2'd1; prbs_sel = 2'd1;
        seed = 31'($urandom);
        s = seed_fix(seed, 15);
        seed_load = 1'b1; out_ready = 1'b0;
        tick();
        seed_load = 1'b0;
        for (int i = 0; i < 600; i++) begin
            out_ready = 1'($urandom);
            if (out_data !== 16'(s) || out_valid !== 1'b1) bad++;
            if (period !== exp_p) pbad++;
            acc = out_ready;
            tick();
            if (acc) begin s = prbs_step(s, 15, 14); n_acc++; end
            exp_p = acc && s == 31'd1;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL bp_words: got %0d wrong words over %0d accepts expected 0", bad, n_acc); end
        n_cmp++; if (pbad != 0) begin n_bad++; $display("FAIL bp_period: got %0d wrong period samples expected 0", pbad); end
        out_ready = 1'b1; en = 1'b0; #1;
        tick(); tick();
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 16'h0000 || period !== 1'b0) begin n_bad++; $display("FAIL en_hold_out: got valid=%b data=%h period=%b expected 0 0000 0", out_valid, out_data, period); end
        en = 1'b1; #1;
        n_cmp++; if (out_data !== 16'(s)) begin n_bad++; $display("FAIL en_hold_state: got %h expected %h", out_data, 16'(s)); end
        out_ready = 1'b0;
    endtask

    task automatic test_remask();
        mode = 2'd1; prbs_sel = 2'd2; out_ready = 1'b0;
        seed = 31'h7FFF_FF80; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        n_cmp++; if (out_data !== 16'hFF80) begin n_bad++; $display("FAIL prbs31_seed: got %h expected ff80", out_data); end
        prbs_sel = 2'd0; #1;
        n_cmp++; if (out_data !== 16'h0000) begin n_bad++; $display("FAIL remask_view: got %h expected 0000", out_data); end
        tick();
        n_cmp++; if (out_data !== 16'h0001) begin n_bad++; $display("FAIL remask_zero: got %h expected 0001", out_data); end
        prbs_sel = 2'd2; seed = 31'h1234_5678; seed_load = 1'b1;
        tick();
        seed_load = 1'b0; prbs_sel = 2'd1;
        tick();
        n_cmp++; if (out_data !== 16'h5678) begin n_bad++; $display("FAIL remask_15: got %h expected 5678", out_data); end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_data !== 16'(prbs_step(31'h5678, 15, 14))) begin n_bad++; $display("FAIL remask_step: got %h expected %h", out_data, 16'(prbs_step(31'h5678, 15, 14))); end
        out_ready = 1'b0;
    endtask

    task automatic test_playback_oneshot();
        for (int i = 0; i < 5; i++) mem_write(i, play_tab[i]);
        mode = 2'd2; len = 5'd5; loop = 1'b0; out_ready = 1'b1;
        pulse_clear();
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (out_data !== play_tab[i] || out_valid !== 1'b1 || period !== 1'b0) begin n_bad++; $display("FAIL oneshot_word%0d: got %h v=%b p=%b expected %h 1 0", i, out_data, out_valid, period, play_tab[i]); end
            tick();
        end
        n_cmp++; if (done !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0000 || period !== 1'b1) begin n_bad++; $display("FAIL oneshot_end: got done=%b v=%b d=%h p=%b expected 1 0 0000 1", done, out_valid, out_data, period); end
        tick();
        n_cmp++; if (done !== 1'b1 || period !== 1'b0) begin n_bad++; $display("FAIL oneshot_sticky: got done=%b p=%b expected 1 0", done, period); end
        len = '0; loop = 1'b1;
        pulse_clear();
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 16'h0000) begin n_bad++; $display("FAIL len0: got v=%b d=%h expected 0 0000", out_valid, out_data); end
    endtask

    task automatic test_playback_loop();
        int bad = 0, pbad = 0, p = 0, l;
        logic exp_p = 1'b0, acc;
        mode = 2'd2; len = 5'd5; loop = 1'b1; out_ready = 1'b1;
        pulse_clear();
        for (int i = 0; i < 12; i++) begin
            if (out_data !== play_tab[i % 5] || done !== 1'b0) bad++;
            if (period !== (i == 5 || i == 10)) pbad++;
            tick();
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL loop_words: got %0d wrong words expected 0", bad); end
        n_cmp++; if (pbad != 0) begin n_bad++; $display("FAIL loop_period: got %0d wrong period samples expected 0", pbad); end
        for (int i = 0; i < DEPTH; i++) mem_write(i, 16'($urandom));
        l = $urandom_range(1, DEPTH);
        len = 5'(l);
        pulse_clear();
        bad = 0; pbad = 0;
        for (int i = 0; i < 60; i++) begin
            out_ready = 1'($urandom);
            if (out_data !== mem_m[p]) bad++;
            if (period !== exp_p) pbad++;
            acc = out_ready;
            tick();
            exp_p = acc && p == l - 1;
            if (acc) p = (p == l - 1) ? 0 : p + 1;
        end
        n_cmp++; if (bad != 0 || pbad != 0) begin n_bad++; $display("FAIL loop_random: got %0d word and %0d period errors with len %0d expected 0", bad, pbad, l); end
        out_ready = 1'b0;
    endtask

    task automatic test_len_shrink();
        mode = 2'd2; len = 5'd8; loop = 1'b1; out_ready = 1'b1;
        pulse_clear();
        repeat (6) tick();
        n_cmp++; if (out_data !== mem_m[6]) begin n_bad++; $display("FAIL shrink_pre: got %h expected %h", out_data, mem_m[6]); end
        len = 5'd3;
        tick();
        n_cmp++; if (out_data !== mem_m[0] || period !== 1'b0) begin n_bad++; $display("FAIL shrink_loop: got %h p=%b expected %h 0", out_data, period, mem_m[0]); end
        len = 5'd8; loop = 1'b0;
        pulse_clear();
        repeat (6) tick();
        len = 5'd3;
        tick();
        n_cmp++; if (done !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL shrink_oneshot: got done=%b v=%b expected 1 0", done, out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_write_through();
        mode = 2'd2; len = 5'd5; loop = 1'b1; out_ready = 1'b0;
        pulse_clear();
        mem_write(0, 16'hBEEF);
        n_cmp++; if (out_data !== 16'hBEEF) begin n_bad++; $display("FAIL write_through: got %h expected beef", out_data); end
        CLEAR = 1'b1;
        mem_write(1, 16'hCAFE);
        CLEAR = 1'b0;
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_data !== 16'hCAFE) begin n_bad++; $display("FAIL write_in_clear: got %h expected cafe", out_data); end
        out_ready = 1'b0;
    endtask

    task automatic test_clear_mid();
        int bad = 0;
        for (int i = 0; i < 5; i++) mem_write(i, play_tab[i]);
        mode = 2'd2; len = 5'd5; loop = 1'b0; out_ready = 1'b1;
        pulse_clear();
        repeat (3) tick();
        n_cmp++; if (out_data !== play_tab[3]) begin n_bad++; $display("FAIL mid_ptr3: got %h expected %h", out_data, play_tab[3]); end
        CLEAR = 1'b1;
        tick();
        n_cmp++; if (out_data !== play_tab[0] || done !== 1'b0) begin n_bad++; $display("FAIL mid_clear: got %h done=%b expected %h 0", out_data, done, play_tab[0]); end
        CLEAR = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (out_data !== play_tab[i]) bad++;
            tick();
        end
        n_cmp++; if (bad != 0 || done !== 1'b1) begin n_bad++; $display("FAIL mid_replay: got %0d wrong words done=%b expected 0 1", bad, done); end
        out_ready = 1'b0;
    endtask

    task automatic test_walking();
        int bad = 0, pbad = 0;
        mode = 2'd3; out_ready = 1'b1;
        pulse_clear();
        for (int i = 0; i <= 16; i++) begin
            if (out_data !== (16'd1 << (i % 16))) bad++;
            if (period !== (i == 16)) pbad++;
            if (i < 16) tick();
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL walk_words: got %0d wrong words expected 0", bad); end
        n_cmp++; if (pbad != 0 || out_data !== 16'h0001) begin n_bad++; $display("FAIL walk_period: got %0d period errors data %h expected 0 0001", pbad, out_data); end
        out_ready = 1'b0;
    endtask

    initial begin
        CLEAR = 1'b1; en = 1'b0; mode = 2'd0; prbs_sel = 2'd0; seed_load = 1'b0; seed = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; len = '0; loop = 1'b0; out_ready = 1'b0;
        test_reset();
        test_counter();
        test_prbs7();
        test_prbs15_seed();
        test_back_pressure();
        test_remask();
        test_playback_oneshot();
        test_playback_loop();
        test_len_shrink();
        test_write_through();
        test_clear_mid();
        test_walking();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
